// File: rtl/test_vector_recorder.sv
// test_vector_recorder: captures {dut_in,dut_out} words into a buffer with synchronous readback.
// Define TVREC_DROP_CNT_EN to count samples ignored while DONE.
module test_vector_recorder #(
  parameter int IN_W        = 3,
  parameter int OUT_W       = 1,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int NUM_VECTORS = 112,
  parameter int CNT_W       = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    sample_valid,
  input  logic [IN_W-1:0]         dut_in,
  input  logic [OUT_W-1:0]        dut_out,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [IN_W+OUT_W-1:0]   rd_data,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        count,
  output logic [CNT_W-1:0]        drop_cnt
);
  localparam int W = IN_W + OUT_W;
  typedef enum logic [1:0] {IDLE, REC, DONE} state_t;
  state_t state, state_nxt;
  logic [W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic go, wr_en, last;
  always_comb begin
    go        = start && state != REC;
    wr_en     = state == REC && sample_valid;
    last      = wr_en && count == CNT_W'(NUM_VECTORS - 1);
    state_nxt = go ? REC :
                (state == REC && (last || abort || count == CNT_W'(NUM_VECTORS))) ? DONE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (go) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      count  <= count + CNT_W'(1);
    end
  // Buffer is deliberately left unreset so captured words survive a reset.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= {dut_in, dut_out};
  always_ff @(posedge clk or posedge reset)
    if (reset) rd_data <= '0;
    else rd_data <= mem[rd_addr];
  assign busy = state == REC;
  assign done = state == DONE;
`ifdef TVREC_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) drop_cnt <= '0;
    else if (go) drop_cnt <= '0;
    else if (state == DONE && sample_valid && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_test_vector_recorder.sv
// tb_test_vector_recorder: scoreboard bench for test_vector_recorder with directed vectors.
module tb_test_vector_recorder;
  logic clk = 0, reset, start, abort, sample_valid, dut_out, rd_req, rd_vld;
  logic [2:0] dut_in;
  logic [9:0] rd_addr;
  logic [3:0] rd_data;
  logic busy, done;
  logic [10:0] count, drop_cnt;
  int n_chk = 0, n_fail = 0;
  typedef struct {string name; int sel; logic [31:0] exp;} chk_t;
  chk_t st_q[$];
  logic [3:0] rd_q[$];
  string rd_n[$];
  event snap;
`ifdef TVREC_DROP_CNT_EN
  localparam logic [10:0] DROP_EXP = 11'd3;
`else
  localparam logic [10:0] DROP_EXP = 11'd0;
`endif

  test_vector_recorder dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .sample_valid(sample_valid),
    .dut_in(dut_in), .dut_out(dut_out), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0: return {31'd0, busy};
      1: return {31'd0, done};
      2: return {21'd0, count};
      3: return {21'd0, drop_cnt};
      default: return {28'd0, rd_data};
    endcase
  endfunction

  // Status monitor: drains queued expectations whenever a snapshot is requested.
  always @(snap)
    while (st_q.size() > 0) begin
      chk_t c;
      c = st_q.pop_front();
      cmp(c.name, actual(c.sel), c.exp);
    end

  // Readback monitor: rd_data is valid one clock after a request.
  always @(posedge clk or posedge reset)
    if (reset) rd_vld <= 0;
    else rd_vld <= rd_req;

  always @(negedge clk)
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_unexpected: got %0h expected none", rd_data);
      end else cmp(rd_n.pop_front(), {28'd0, rd_data}, {28'd0, rd_q.pop_front()});
    end

  task automatic chk(input string n, input int sel, input logic [31:0] e);
    st_q.push_back('{n, sel, e});
    -> snap;
  endtask

  task automatic step(input logic st, input logic ab, input logic sv, input logic [2:0] di, input logic dq);
    start = st; abort = ab; sample_valid = sv; dut_in = di; dut_out = dq;
    @(negedge clk);
    start = 0; abort = 0; sample_valid = 0; rd_req = 0;
  endtask

  task automatic samp(input int i);
    logic [6:0] v;
    v = 7'(i);
    step(0, 0, 1, v[2:0], ^v);
  endtask

  task automatic issue_rd(input string n, input logic [9:0] a, input logic [3:0] e);
    rd_addr = a; rd_req = 1;
    rd_q.push_back(e); rd_n.push_back(n);
  endtask

  task automatic read(input string n, input logic [9:0] a, input logic [3:0] e);
    issue_rd(n, a, e);
    step(0, 0, 0, 3'd0, 1'b0);
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; sample_valid = 0; dut_in = 0; dut_out = 0;
    rd_addr = 0; rd_req = 0;
    #3;
    chk("rst_busy", 0, 0); chk("rst_done", 1, 0); chk("rst_count", 2, 0);
    chk("rst_drop", 3, 0); chk("rst_rd", 4, 0);
    @(negedge clk); reset = 0;
    step(0, 1, 0, 3'd0, 1'b0);
    chk("idle_abort_busy", 0, 0); chk("idle_abort_done", 1, 0);
    // Full run of NUM_VECTORS samples
    step(1, 0, 0, 3'd0, 1'b0);
    chk("start_count", 2, 0); chk("start_busy", 0, 1);
    for (int i = 0; i < 112; i++) begin
      samp(i);
      if (i == 110) begin
        chk("c111_count", 2, 111); chk("c111_busy", 0, 1); chk("c111_done", 1, 0);
      end
    end
    chk("full_count", 2, 112); chk("full_done", 1, 1); chk("full_busy", 0, 0);
    read("rd5", 10'd5, 4'b1010);
    read("rd0", 10'd0, 4'b0000);
    read("rd7", 10'd7, 4'b1111);
    read("rd111", 10'd111, 4'b1110);
    // Abort together with the 11th sample; first write also probes read-during-write
    step(1, 0, 0, 3'd0, 1'b0);
    for (int j = 0; j < 11; j++) begin
      logic [3:0] jj;
      jj = 4'(j);
      if (j == 0) issue_rd("rdw_old", 10'd0, 4'b0000);
      step(0, j == 10, 1, 3'(7 - j), ~jj[0]);
    end
    chk("abort_count", 2, 11); chk("abort_done", 1, 1); chk("abort_busy", 0, 0);
    read("abort_rd10", 10'd10, 4'b1011);
    read("abort_rd0", 10'd0, 4'b1111);
    // DONE: abort ignored, samples dropped
    step(0, 1, 0, 3'd0, 1'b0);
    chk("done_abort_done", 1, 1);
    repeat (3) step(0, 0, 1, 3'b110, 1'b1);
    chk("drop_count", 2, 11); chk("drop_cnt", 3, DROP_EXP); chk("drop_done", 1, 1);
    read("drop_rd11", 10'd11, 4'b0111);
    // sample_valid on the start cycle is not stored
    step(1, 0, 1, 3'b010, 1'b0);
    chk("s6_count", 2, 0); chk("s6_busy", 0, 1); chk("s6_drop", 3, 0);
    read("s6_rd0", 10'd0, 4'b1111);
    chk("s6_count2", 2, 0);
    // start during REC is ignored
    for (int i = 0; i < 20; i++) samp(i);
    step(1, 0, 0, 3'd0, 1'b0);
    chk("s5_count", 2, 20); chk("s5_busy", 0, 1);
    for (int i = 20; i < 112; i++) samp(i);
    chk("s5_full", 2, 112); chk("s5_done", 1, 1);
    step(1, 1, 0, 3'd0, 1'b0);
    chk("restart_count", 2, 0); chk("restart_busy", 0, 1); chk("restart_done", 1, 0);
    read("restart_rd5", 10'd5, 4'b1010);
    // Asynchronous reset mid-cycle
    @(posedge clk); #2 reset = 1; #1;
    chk("mrst_busy", 0, 0); chk("mrst_done", 1, 0); chk("mrst_count", 2, 0); chk("mrst_rd", 4, 0);
    #10 reset = 0;
    repeat (2) @(negedge clk);
    if (st_q.size() != 0 || rd_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: got %0d expected 0 pending", st_q.size() + rd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
